// File: rtl/rf_arb_pkg.sv
// Shared types and widths for the register-file write-port arbiter.
package rf_arb_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned NUM_REGS   = 1 << REG_ADDR_W;

   typedef enum logic [1:0] {
      IDLE,
      PENDING,
      STARVED
   } arb_state_t;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } rf_wr_t;

endpackage

// File: rtl/rf_arb_fifo.sv
// Small synchronous FIFO holding buffered multi-cycle writes {rd, data}.
module rf_arb_fifo
   import rf_arb_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  rf_wr_t           push_data,
   input  logic             pop,
   output rf_wr_t           head,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   rf_wr_t           mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push, do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem_q[rd_ptr_q];
   assign count   = count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
            wr_ptr_q        <= ptr_inc(wr_ptr_q);
         end
         if (do_pop) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         if (do_push && !do_pop) begin
            count_q <= count_q + CNT_W'(1);
         end else if (do_pop && !do_push) begin
            count_q <= count_q - CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between WB (always wins) and buffered
// multi-cycle results; tracks pending destinations and requests bubbles on starvation.
module rf_write_arbiter
   import rf_arb_pkg::*;
#(
   parameter int unsigned DEPTH        = 2,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wb_we_i,
   input  logic [REG_ADDR_W-1:0] wb_rd_i,
   input  logic [XLEN-1:0]       wb_data_i,
   input  logic                  mc_issue_i,
   input  logic [REG_ADDR_W-1:0] mc_issue_rd_i,
   input  logic                  mc_valid_i,
   input  logic [REG_ADDR_W-1:0] mc_rd_i,
   input  logic [XLEN-1:0]       mc_data_i,
   output logic                  mc_ready_o,
   output logic                  rf_we_o,
   output logic [REG_ADDR_W-1:0] rf_rd_o,
   output logic [XLEN-1:0]       rf_wdata_o,
   output logic [NUM_REGS-1:0]   busy_o,
   output logic                  stall_req_o
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned BLK_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(STARVE_LIMIT);

   logic                wb_claim, push, pop, fifo_drains;
   logic                fifo_full, fifo_empty;
   logic [CNT_W-1:0]    fifo_count;
   rf_wr_t              head, push_data;
   logic [BLK_W-1:0]    blk_cnt_q, blk_cnt_d;
   logic [NUM_REGS-1:0] busy_q, busy_d;
   arb_state_t          state_q;

   assign wb_claim    = wb_we_i && (wb_rd_i != '0);
   assign pop         = !wb_claim && !fifo_empty;
   assign mc_ready_o  = !fifo_full;
   // rd=0 results are handshaked but never stored
   assign push        = mc_valid_i && mc_ready_o && (mc_rd_i != '0);
   assign push_data   = '{rd: mc_rd_i, data: mc_data_i};
   assign fifo_drains = pop && !push && (fifo_count == CNT_W'(1));

   rf_arb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_comb begin
      rf_we_o    = 1'b0;
      rf_rd_o    = '0;
      rf_wdata_o = '0;
      if (wb_claim) begin
         rf_we_o    = 1'b1;
         rf_rd_o    = wb_rd_i;
         rf_wdata_o = wb_data_i;
      end else if (!fifo_empty) begin
         rf_we_o    = 1'b1;
         rf_rd_o    = head.rd;
         rf_wdata_o = head.data;
      end
   end

   // Set is applied after clear so a same-cycle re-issue keeps the bit
   always_comb begin
      busy_d = busy_q;
      if (pop) begin
         busy_d[head.rd] = 1'b0;
      end
      if (mc_issue_i && (mc_issue_rd_i != '0)) begin
         busy_d[mc_issue_rd_i] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_comb begin
      blk_cnt_d = blk_cnt_q;
      if (pop) begin
         blk_cnt_d = '0;
      end else if (wb_claim && !fifo_empty && (blk_cnt_q != BLK_MAX)) begin
         blk_cnt_d = blk_cnt_q + BLK_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q    <= '0;
         blk_cnt_q <= '0;
      end else begin
         busy_q    <= busy_d;
         blk_cnt_q <= blk_cnt_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (push) state_q <= PENDING;
            end
            PENDING: begin
               if (fifo_drains) begin
                  state_q <= IDLE;
               end else if (blk_cnt_d == BLK_MAX) begin
                  state_q <= STARVED;
               end
            end
            STARVED: begin
               if (pop) state_q <= fifo_drains ? IDLE : PENDING;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy_o      = busy_q;
   assign stall_req_o = (state_q == STARVED);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter (DEPTH=2, STARVE_LIMIT=8).
module tb_rf_write_arbiter;

   logic        clk;
   logic        rst_n;
   logic        wb_we_i;
   logic [4:0]  wb_rd_i;
   logic [31:0] wb_data_i;
   logic        mc_issue_i;
   logic [4:0]  mc_issue_rd_i;
   logic        mc_valid_i;
   logic [4:0]  mc_rd_i;
   logic [31:0] mc_data_i;
   logic        mc_ready_o;
   logic        rf_we_o;
   logic [4:0]  rf_rd_o;
   logic [31:0] rf_wdata_o;
   logic [31:0] busy_o;
   logic        stall_req_o;

   int n_cmp = 0;
   int n_err = 0;

   rf_write_arbiter #(
      .DEPTH        (2),
      .STARVE_LIMIT (8)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .wb_we_i       (wb_we_i),
      .wb_rd_i       (wb_rd_i),
      .wb_data_i     (wb_data_i),
      .mc_issue_i    (mc_issue_i),
      .mc_issue_rd_i (mc_issue_rd_i),
      .mc_valid_i    (mc_valid_i),
      .mc_rd_i       (mc_rd_i),
      .mc_data_i     (mc_data_i),
      .mc_ready_o    (mc_ready_o),
      .rf_we_o       (rf_we_o),
      .rf_rd_o       (rf_rd_o),
      .rf_wdata_o    (rf_wdata_o),
      .busy_o        (busy_o),
      .stall_req_o   (stall_req_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      wb_we_i       = 1'b0;
      wb_rd_i       = '0;
      wb_data_i     = '0;
      mc_issue_i    = 1'b0;
      mc_issue_rd_i = '0;
      mc_valid_i    = 1'b0;
      mc_rd_i       = '0;
      mc_data_i     = '0;
   endtask

   task automatic drive_wb(input logic [4:0] rd, input logic [31:0] data);
      wb_we_i   = 1'b1;
      wb_rd_i   = rd;
      wb_data_i = data;
   endtask

   task automatic drive_mc(input logic [4:0] rd, input logic [31:0] data);
      mc_valid_i = 1'b1;
      mc_rd_i    = rd;
      mc_data_i  = data;
   endtask

   task automatic check_write(input string tag, input logic we, input logic [4:0] rd,
                              input logic [31:0] data);
      check({tag, "_we"}, {31'b0, rf_we_o}, {31'b0, we});
      check({tag, "_rd"}, {27'b0, rf_rd_o}, {27'b0, rd});
      check({tag, "_wdata"}, rf_wdata_o, data);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1);
   end

   initial begin
      // Reset held with a result offered: nothing may be written or buffered
      idle_inputs();
      rst_n = 1'b0;
      drive_mc(5'd3, 32'h3333_3333);
      @(negedge clk);
      check_write("rst_hold", 1'b0, 5'd0, 32'h0);
      check("rst_hold_busy", busy_o, 32'h0);
      tick();
      rst_n = 1'b1;
      idle_inputs();
      @(negedge clk);
      check("rst_rel_ready", {31'b0, mc_ready_o}, 32'd1);
      check("rst_rel_busy", busy_o, 32'h0);
      check("rst_rel_stall", {31'b0, stall_req_o}, 32'd0);
      check_write("rst_rel", 1'b0, 5'd0, 32'h0);
      tick();

      // Issue x5, result three cycles later with WB idle
      mc_issue_i    = 1'b1;
      mc_issue_rd_i = 5'd5;
      tick();
      idle_inputs();
      @(negedge clk);
      check("issue_busy", busy_o, 32'h0000_0020);
      tick();
      tick();
      drive_mc(5'd5, 32'h0000_1234);
      @(negedge clk);
      check_write("push_cycle", 1'b0, 5'd0, 32'h0);
      tick();
      idle_inputs();
      @(negedge clk);
      check_write("drain_x5", 1'b1, 5'd5, 32'h0000_1234);
      check("drain_busy_pre", busy_o, 32'h0000_0020);
      tick();
      @(negedge clk);
      check("drain_busy_post", busy_o, 32'h0);
      check_write("drain_after", 1'b0, 5'd0, 32'h0);
      tick();

      // Buffer x5 while WB holds the port, then block it for 8 cycles
      mc_issue_i    = 1'b1;
      mc_issue_rd_i = 5'd5;
      drive_mc(5'd5, 32'h0000_5555);
      drive_wb(5'd7, 32'h0000_AAAA);
      tick();
      idle_inputs();
      for (int i = 0; i < 8; i++) begin
         drive_wb(5'd7, 32'h0000_AAAA + 32'(i));
         @(negedge clk);
         check($sformatf("blk%0d_stall", i), {31'b0, stall_req_o}, 32'd0);
         check_write($sformatf("blk%0d", i), 1'b1, 5'd7, 32'h0000_AAAA + 32'(i));
         tick();
      end
      idle_inputs();
      @(negedge clk);
      check("starved_stall", {31'b0, stall_req_o}, 32'd1);
      check("starved_busy", busy_o, 32'h0000_0020);
      check_write("starved_pop", 1'b1, 5'd5, 32'h0000_5555);
      tick();
      @(negedge clk);
      check("unstarved_stall", {31'b0, stall_req_o}, 32'd0);
      check("unstarved_busy", busy_o, 32'h0);
      tick();

      // Fill the buffer behind WB; third result must be held off
      drive_wb(5'd9, 32'h0000_0009);
      drive_mc(5'd10, 32'h0000_00A0);
      @(negedge clk);
      check("fill0_ready", {31'b0, mc_ready_o}, 32'd1);
      tick();
      drive_mc(5'd11, 32'h0000_00B0);
      @(negedge clk);
      check("fill1_ready", {31'b0, mc_ready_o}, 32'd1);
      tick();
      drive_mc(5'd12, 32'h0000_00C0);
      @(negedge clk);
      check("full_ready", {31'b0, mc_ready_o}, 32'd0);
      check_write("full_wb", 1'b1, 5'd9, 32'h0000_0009);
      tick();
      wb_we_i = 1'b0;
      @(negedge clk);
      check("pop1_ready", {31'b0, mc_ready_o}, 32'd0);
      check_write("pop1", 1'b1, 5'd10, 32'h0000_00A0);
      tick();
      @(negedge clk);
      check("pop2_ready", {31'b0, mc_ready_o}, 32'd1);
      check_write("pop2", 1'b1, 5'd11, 32'h0000_00B0);
      tick();
      idle_inputs();
      @(negedge clk);
      check_write("pop3", 1'b1, 5'd12, 32'h0000_00C0);
      tick();
      @(negedge clk);
      check_write("fifo_empty", 1'b0, 5'd0, 32'h0);
      check("fifo_empty_stall", {31'b0, stall_req_o}, 32'd0);
      tick();

      // Everything targeting x0 is dropped
      drive_wb(5'd0, 32'h0000_DEAD);
      mc_issue_i    = 1'b1;
      mc_issue_rd_i = 5'd0;
      drive_mc(5'd0, 32'h0000_BEEF);
      @(negedge clk);
      check_write("x0_wb", 1'b0, 5'd0, 32'h0);
      check("x0_ready", {31'b0, mc_ready_o}, 32'd1);
      tick();
      idle_inputs();
      @(negedge clk);
      check_write("x0_nopush", 1'b0, 5'd0, 32'h0);
      check("x0_busy", busy_o, 32'h0);
      tick();

      // Pop of x6 and re-issue of x6 in the same cycle: set wins
      drive_wb(5'd1, 32'h0000_0001);
      drive_mc(5'd6, 32'h0000_0066);
      tick();
      idle_inputs();
      mc_issue_i    = 1'b1;
      mc_issue_rd_i = 5'd6;
      @(negedge clk);
      check_write("setwins_pop", 1'b1, 5'd6, 32'h0000_0066);
      tick();
      idle_inputs();
      @(negedge clk);
      check("setwins_busy", busy_o, 32'h0000_0040);
      tick();

      // Asynchronous reset mid-operation with a buffered result
      drive_wb(5'd1, 32'h0000_0001);
      drive_mc(5'd3, 32'h0000_0033);
      mc_issue_i    = 1'b1;
      mc_issue_rd_i = 5'd3;
      tick();
      idle_inputs();
      #2;
      rst_n = 1'b0;
      #1;
      check("async_busy", busy_o, 32'h0);
      check("async_ready", {31'b0, mc_ready_o}, 32'd1);
      check("async_stall", {31'b0, stall_req_o}, 32'd0);
      check_write("async_flush", 1'b0, 5'd0, 32'h0);
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      check_write("post_async", 1'b0, 5'd0, 32'h0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
